// File: rtl/decode_stage_hs.sv
// RV32I decode stage with valid/ready handshake, D->E pipeline register, load-use interlock,
// flush, write-back bypass and a saturating interlock-stall counter.
module decode_stage_hs #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_ADDR  = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic [XLEN-1:0]     pcD,
  input  logic [XLEN-1:0]     instrD,
  output logic                readyD,
  input  logic                flushD,
  input  logic                readyE,
  input  logic                regWriteW,
  input  logic [REG_ADDR-1:0] writeRegW,
  input  logic [XLEN-1:0]     resultW,
  output logic [REG_ADDR-1:0] raddr1D,
  output logic [REG_ADDR-1:0] raddr2D,
  output logic                validE,
  output logic                regWriteE,
  output logic                memWriteE,
  output logic                mem2regE,
  output logic                branchE,
  output logic                finishE,
  output logic                illegalE,
  output logic [3:0]          ALUControlE,
  output logic [1:0]          ALUSrcE,
  output logic [XLEN-1:0]     rdata1E,
  output logic [XLEN-1:0]     rdata2E,
  output logic [XLEN-1:0]     immE,
  output logic [XLEN-1:0]     pcE,
  output logic [REG_ADDR-1:0] writeRegE,
  output logic [REG_ADDR-1:0] raddr1E,
  output logic [REG_ADDR-1:0] raddr2E,
  output logic [CNT_W-1:0]    stallCount
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  // ALU source select: 0 = rs2, 1 = immediate, 2 = pc-relative
  localparam logic [1:0] SrcReg = 2'd0;
  localparam logic [1:0] SrcImm = 2'd1;
  localparam logic [1:0] SrcPc  = 2'd2;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [31:0]         imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [XLEN-1:0]     imm_d;
  logic [3:0]          alu_fn, alu_ctl;
  logic [1:0]          alu_src;
  logic                reg_write, mem_write, mem2reg, branch, finish, illegal;
  logic                uses1, uses2;
  logic [REG_ADDR-1:0] rd_d;
  logic [XLEN-1:0]     rdata1_d, rdata2_d;
  logic                hz, adv;
  logic [XLEN-1:0]     regs [REG_COUNT];

  assign opcode  = instrD[6:0];
  assign funct3  = instrD[14:12];
  assign rd_d    = REG_ADDR'(instrD[11:7]);
  assign raddr1D = REG_ADDR'(instrD[19:15]);
  assign raddr2D = REG_ADDR'(instrD[24:20]);

  assign imm_i = {{20{instrD[31]}}, instrD[31:20]};
  assign imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
  assign imm_b = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
  assign imm_u = {instrD[31:12], 12'b0};
  assign imm_j = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
  assign imm_d = XLEN'($signed(imm32));

  always_comb begin
    alu_fn = AluAdd;
    case (funct3)
      3'b000:  alu_fn = (opcode == OpOp && instrD[30]) ? AluSub : AluAdd;
      3'b001:  alu_fn = AluSll;
      3'b010:  alu_fn = AluSlt;
      3'b011:  alu_fn = AluSltu;
      3'b100:  alu_fn = AluXor;
      3'b101:  alu_fn = instrD[30] ? AluSra : AluSrl;
      3'b110:  alu_fn = AluOr;
      default: alu_fn = AluAnd;
    endcase
  end

  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    branch    = 1'b0;
    finish    = 1'b0;
    illegal   = 1'b0;
    alu_ctl   = AluAdd;
    alu_src   = SrcReg;
    imm32     = '0;
    uses1     = 1'b1;
    uses2     = 1'b0;
    case (opcode)
      OpLui:    begin reg_write = 1'b1; alu_src = SrcImm; imm32 = imm_u; uses1 = 1'b0; end
      OpAuipc:  begin reg_write = 1'b1; alu_src = SrcPc;  imm32 = imm_u; end
      OpJal: begin
        reg_write = 1'b1; branch = 1'b1; alu_src = SrcPc; imm32 = imm_j; uses1 = 1'b0;
      end
      OpJalr:   begin reg_write = 1'b1; branch = 1'b1; alu_src = SrcImm; imm32 = imm_i; end
      OpBranch: begin branch = 1'b1; alu_ctl = AluSub; imm32 = imm_b; uses2 = 1'b1; end
      OpLoad:   begin reg_write = 1'b1; mem2reg = 1'b1; alu_src = SrcImm; imm32 = imm_i; end
      OpStore:  begin mem_write = 1'b1; alu_src = SrcImm; imm32 = imm_s; uses2 = 1'b1; end
      OpOpImm:  begin reg_write = 1'b1; alu_src = SrcImm; imm32 = imm_i; alu_ctl = alu_fn; end
      OpOp:     begin reg_write = 1'b1; alu_ctl = alu_fn; uses2 = 1'b1; end
      default:  begin finish = 1'b1; illegal = 1'b1; end
    endcase
  end

  // Same-cycle write-back wins over the stored value; x0 always reads zero.
  always_comb begin
    rdata1_d = '0;
    rdata2_d = '0;
    if (raddr1D != '0) begin
      if (regWriteW && writeRegW == raddr1D) rdata1_d = resultW;
      else if (32'(raddr1D) < REG_COUNT)     rdata1_d = regs[raddr1D];
    end
    if (raddr2D != '0) begin
      if (regWriteW && writeRegW == raddr2D) rdata2_d = resultW;
      else if (32'(raddr2D) < REG_COUNT)     rdata2_d = regs[raddr2D];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (regWriteW && writeRegW != '0 && 32'(writeRegW) < REG_COUNT) begin
      regs[writeRegW] <= resultW;
    end
  end

  assign hz = validD && validE && mem2regE && (writeRegE != '0) &&
              ((uses1 && raddr1D == writeRegE) || (uses2 && raddr2D == writeRegE));
  assign adv    = !validE || readyE;
  assign readyD = flushD || (adv && !hz);

  always_ff @(posedge clk) begin
    if (reset) begin
      validE      <= 1'b0;
      regWriteE   <= 1'b0;
      memWriteE   <= 1'b0;
      mem2regE    <= 1'b0;
      branchE     <= 1'b0;
      finishE     <= 1'b0;
      illegalE    <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= '0;
      rdata1E     <= '0;
      rdata2E     <= '0;
      immE        <= '0;
      pcE         <= '0;
      writeRegE   <= '0;
      raddr1E     <= '0;
      raddr2E     <= '0;
    end else if (adv) begin
      if (flushD || hz || !validD) begin
        // Bubble: only the control bits matter, data fields are left as they were.
        validE    <= 1'b0;
        regWriteE <= 1'b0;
        memWriteE <= 1'b0;
        mem2regE  <= 1'b0;
        branchE   <= 1'b0;
        finishE   <= 1'b0;
        illegalE  <= 1'b0;
      end else begin
        validE      <= 1'b1;
        regWriteE   <= reg_write;
        memWriteE   <= mem_write;
        mem2regE    <= mem2reg;
        branchE     <= branch;
        finishE     <= finish;
        illegalE    <= illegal;
        ALUControlE <= alu_ctl;
        ALUSrcE     <= alu_src;
        rdata1E     <= rdata1_d;
        rdata2E     <= rdata2_d;
        immE        <= imm_d;
        pcE         <= pcD;
        writeRegE   <= rd_d;
        raddr1E     <= raddr1D;
        raddr2E     <= raddr2D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
    end else if (adv && hz && !flushD && stallCount != '1) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: directed scenarios plus a randomized run against a transaction model.
module tb_decode_stage_hs;

  typedef struct packed {
    logic        valid, rw, mw, m2r, br, fin, ill;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [31:0] r1, r2, imm, pc;
    logic [4:0]  rd, rs1, rs2;
  } e_t;

  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  logic clk = 1'b0, reset = 1'b1, validD = 1'b0, flushD = 1'b0, readyE = 1'b1;
  logic regWriteW = 1'b0;
  logic [31:0] pcD = '0, instrD = '0, resultW = '0;
  logic [4:0]  writeRegW = '0;

  logic readyD, validE, regWriteE, memWriteE, mem2regE, branchE, finishE, illegalE;
  logic [4:0] raddr1D, raddr2D, writeRegE, raddr1E, raddr2E;
  logic [3:0] ALUControlE;
  logic [1:0] ALUSrcE;
  logic [31:0] rdata1E, rdata2E, immE, pcE;
  logic [15:0] stallCount;

  logic s_readyD, s_validE, s_regWriteE, s_memWriteE, s_mem2regE, s_branchE, s_finishE, s_illegalE;
  logic [4:0] s_raddr1D, s_raddr2D, s_writeRegE, s_raddr1E, s_raddr2E;
  logic [3:0] s_ALUControlE;
  logic [1:0] s_ALUSrcE;
  logic [31:0] s_rdata1E, s_rdata2E, s_immE, s_pcE;
  logic [1:0] s_stallCount;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decode_stage_hs u_dut (
    .clk(clk), .reset(reset), .validD(validD), .pcD(pcD), .instrD(instrD), .readyD(readyD),
    .flushD(flushD), .readyE(readyE), .regWriteW(regWriteW), .writeRegW(writeRegW),
    .resultW(resultW), .raddr1D(raddr1D), .raddr2D(raddr2D), .validE(validE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .mem2regE(mem2regE), .branchE(branchE),
    .finishE(finishE), .illegalE(illegalE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE), .writeRegE(writeRegE),
    .raddr1E(raddr1E), .raddr2E(raddr2E), .stallCount(stallCount)
  );

  decode_stage_hs #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .validD(validD), .pcD(pcD), .instrD(instrD), .readyD(s_readyD),
    .flushD(flushD), .readyE(readyE), .regWriteW(regWriteW), .writeRegW(writeRegW),
    .resultW(resultW), .raddr1D(s_raddr1D), .raddr2D(s_raddr2D), .validE(s_validE),
    .regWriteE(s_regWriteE), .memWriteE(s_memWriteE), .mem2regE(s_mem2regE),
    .branchE(s_branchE), .finishE(s_finishE), .illegalE(s_illegalE),
    .ALUControlE(s_ALUControlE), .ALUSrcE(s_ALUSrcE), .rdata1E(s_rdata1E), .rdata2E(s_rdata2E),
    .immE(s_immE), .pcE(s_pcE), .writeRegE(s_writeRegE), .raddr1E(s_raddr1E),
    .raddr2E(s_raddr2E), .stallCount(s_stallCount)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  e_t          m_e;
  int          m_cnt, m_cnt_sat;

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] t;
    t = v << (32 - bits);
    return $signed(t) >>> (32 - bits);
  endfunction

  function automatic e_t ref_decode(input logic [31:0] ins, output logic u1, output logic u2);
    e_t e;
    logic [2:0] f3;
    e = '0;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    f3 = ins[14:12];
    u1 = 1'b1; u2 = 1'b0;
    case (ins[6:0])
      7'h37: begin e.rw = 1; e.src = 1; e.imm = ins & 32'hFFFFF000; u1 = 0; end
      7'h17: begin e.rw = 1; e.src = 2; e.imm = ins & 32'hFFFFF000; end
      7'h6F: begin
        e.rw = 1; e.br = 1; e.src = 2; u1 = 0;
        e.imm = sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hff) << 12) |
                   (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3ff) << 1), 21);
      end
      7'h67: begin e.rw = 1; e.br = 1; e.src = 1; e.imm = sx(ins >> 20, 12); end
      7'h63: begin
        e.br = 1; e.alu = 4'd1; u2 = 1;
        e.imm = sx((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                   (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1), 13);
      end
      7'h03: begin e.rw = 1; e.m2r = 1; e.src = 1; e.imm = sx(ins >> 20, 12); end
      7'h23: begin
        e.mw = 1; e.src = 1; u2 = 1;
        e.imm = sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1f), 12);
      end
      7'h13: begin
        e.rw = 1; e.src = 1; e.imm = sx(ins >> 20, 12); e.alu = ALU_TAB[f3];
        if (f3 == 3'd5 && ins[30]) e.alu = 4'd7;
      end
      7'h33: begin
        e.rw = 1; u2 = 1; e.alu = ALU_TAB[f3];
        if (f3 == 3'd0 && ins[30]) e.alu = 4'd1;
        if (f3 == 3'd5 && ins[30]) e.alu = 4'd7;
      end
      default: begin e.fin = 1; e.ill = 1; end
    endcase
    return e;
  endfunction

  // Value a D-stage read sees: pending write-back first, x0 is zero.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (regWriteW && writeRegW == a) return resultW;
    return m_regs[a];
  endfunction

  function automatic e_t dut_e();
    return {validE, regWriteE, memWriteE, mem2regE, branchE, finishE, illegalE, ALUControlE,
            ALUSrcE, rdata1E, rdata2E, immE, pcE, writeRegE, raddr1E, raddr2E};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    validD = 0; flushD = 0; readyE = 1; regWriteW = 0; writeRegW = 0; resultW = 0;
    instrD = 0; pcD = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    e_t a;
    drive_idle();
    do_reset();
    a = dut_e();
    n_checks++; if (a !== '0) $display("FAIL reset_e: got %h want 0", a); else n_pass++;
    n_checks++; if (stallCount !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", stallCount);
    else n_pass++;
    n_checks++; if (readyD !== 1'b1) $display("FAIL reset_readyD: got %b want 1", readyD);
    else n_pass++;
  endtask

  task automatic test_addi();
    validD = 1; instrD = 32'h00500093; pcD = 32'h100;
    #1;
    n_checks++; if (readyD !== 1'b1) $display("FAIL addi_readyD: got %b want 1", readyD);
    else n_pass++;
    tick();
    validD = 0;
    n_checks++;
    if ({validE, ALUControlE, ALUSrcE, regWriteE} !== {1'b1, 4'd0, 2'd1, 1'b1})
      $display("FAIL addi_ctl: got %b %h %h %b want 1 0 1 1", validE, ALUControlE, ALUSrcE,
               regWriteE);
    else n_pass++;
    n_checks++;
    if ({immE, writeRegE, rdata1E, pcE} !== {32'd5, 5'd1, 32'd0, 32'h100})
      $display("FAIL addi_data: got imm %h rd %0d r1 %h pc %h", immE, writeRegE, rdata1E, pcE);
    else n_pass++;
  endtask

  task automatic test_bypass();
    regWriteW = 1; writeRegW = 3; resultW = 32'hDEADBEEF;
    validD = 1; instrD = 32'h00318233;
    tick();
    regWriteW = 0;
    n_checks++;
    if ({rdata1E, rdata2E} !== {32'hDEADBEEF, 32'hDEADBEEF})
      $display("FAIL bypass: got %h %h want deadbeef deadbeef", rdata1E, rdata2E);
    else n_pass++;
    tick();
    validD = 0;
    n_checks++;
    if (rdata1E !== 32'hDEADBEEF) $display("FAIL rf_read: got %h want deadbeef", rdata1E);
    else n_pass++;
  endtask

  task automatic test_load_use();
    validD = 1; instrD = 32'h00012283;
    tick();
    instrD = 32'h00128333;
    #1;
    n_checks++; if (readyD !== 1'b0) $display("FAIL lu_readyD: got %b want 0", readyD);
    else n_pass++;
    tick();
    n_checks++; if (validE !== 1'b0) $display("FAIL lu_bubble: got %b want 0", validE);
    else n_pass++;
    n_checks++; if (stallCount !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", stallCount);
    else n_pass++;
    n_checks++; if (readyD !== 1'b1) $display("FAIL lu_ready2: got %b want 1", readyD);
    else n_pass++;
    tick();
    n_checks++;
    if ({validE, writeRegE, raddr1E} !== {1'b1, 5'd6, 5'd5})
      $display("FAIL lu_issue: got %b rd %0d rs1 %0d want 1 6 5", validE, writeRegE, raddr1E);
    else n_pass++;
    instrD = 32'h00012283;
    tick();
    instrD = 32'h00108333;
    #1;
    n_checks++; if (readyD !== 1'b1) $display("FAIL nohz_readyD: got %b want 1", readyD);
    else n_pass++;
    tick();
    validD = 0;
    n_checks++;
    if ({validE, writeRegE, stallCount} !== {1'b1, 5'd6, 16'd1})
      $display("FAIL nohz_issue: got %b %0d cnt %0d want 1 6 1", validE, writeRegE, stallCount);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    validD = 1; instrD = 32'h00500093;
    tick();
    readyE = 0; instrD = 32'h00900393;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (readyD !== 1'b0) $display("FAIL bp_readyD %0d: got %b want 0", i, readyD);
      else n_pass++;
      tick();
      n_checks++;
      if ({validE, writeRegE, immE} !== {1'b1, 5'd1, 32'd5})
        $display("FAIL bp_hold %0d: got %b %0d %h want 1 1 5", i, validE, writeRegE, immE);
      else n_pass++;
    end
    readyE = 1;
    #1;
    n_checks++; if (readyD !== 1'b1) $display("FAIL bp_release: got %b want 1", readyD);
    else n_pass++;
    tick();
    n_checks++;
    if ({writeRegE, immE} !== {5'd7, 32'd9})
      $display("FAIL bp_next: got %0d %h want 7 9", writeRegE, immE);
    else n_pass++;
  endtask

  task automatic test_flush();
    validD = 1; flushD = 1; instrD = 32'h00900393;
    #1;
    n_checks++; if (readyD !== 1'b1) $display("FAIL flush_readyD: got %b want 1", readyD);
    else n_pass++;
    tick();
    flushD = 0;
    n_checks++;
    if ({validE, regWriteE} !== 2'b00) $display("FAIL flush_e: got %b %b want 0 0", validE,
                                                 regWriteE);
    else n_pass++;
  endtask

  task automatic test_x0();
    regWriteW = 1; writeRegW = 0; resultW = 32'h12345678;
    validD = 1; instrD = 32'h00000233;
    tick();
    regWriteW = 0;
    n_checks++; if (rdata1E !== 32'd0) $display("FAIL x0_bypass: got %h want 0", rdata1E);
    else n_pass++;
    tick();
    validD = 0;
    n_checks++; if (rdata2E !== 32'd0) $display("FAIL x0_read: got %h want 0", rdata2E);
    else n_pass++;
  endtask

  task automatic test_saturate_illegal();
    drive_idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      validD = 1; instrD = 32'h00012283;
      tick();
      instrD = 32'h00128333;
      tick();
      tick();
      n_checks++;
      if (s_stallCount !== 2'((i + 1 > 3) ? 3 : i + 1))
        $display("FAIL sat_cnt %0d: got %0d want %0d", i, s_stallCount, (i + 1 > 3) ? 3 : i + 1);
      else n_pass++;
    end
    n_checks++; if (stallCount !== 16'd5) $display("FAIL wide_cnt: got %0d want 5", stallCount);
    else n_pass++;
    instrD = 32'h0000007F;
    tick();
    n_checks++;
    if ({validE, illegalE, finishE, regWriteE, memWriteE, branchE} !== 6'b111000)
      $display("FAIL illegal: got %b%b%b%b%b%b want 111000", validE, illegalE, finishE,
               regWriteE, memWriteE, branchE);
    else n_pass++;
    // reset arriving while a load-use bubble is pending
    instrD = 32'h00012283;
    tick();
    instrD = 32'h00128333;
    reset = 1;
    tick();
    reset = 0; validD = 0;
    n_checks++;
    if ({validE, stallCount, s_stallCount} !== {1'b0, 16'd0, 2'd0})
      $display("FAIL reset_stall: got %b %0d %0d want 0 0 0", validE, stallCount, s_stallCount);
    else n_pass++;
  endtask

  task automatic test_random();
    e_t d, a;
    logic u1, u2, hz, adv, rdy;
    logic [31:0] ins;
    logic [6:0] op;
    int kind;
    drive_idle();
    do_reset();
    m_e = '0; m_cnt = 0; m_cnt_sat = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int c = 0; c < 600; c++) begin
      kind = $urandom_range(0, 11);
      case (kind)
        0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;  4: op = 7'h63;
        8: op = 7'h23;  9: op = 7'h13;  10: op = 7'h33; 11: op = 7'h7F;
        default: op = 7'h03;
      endcase
      ins = $urandom;
      ins[6:0] = op;
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      instrD = ins; pcD = $urandom;
      validD = ($urandom_range(0, 3) != 0);
      flushD = ($urandom_range(0, 9) == 0);
      readyE = ($urandom_range(0, 3) != 0);
      regWriteW = 1'($urandom_range(0, 1));
      writeRegW = 5'($urandom_range(0, 7));
      resultW = $urandom;
      #1;
      d = ref_decode(ins, u1, u2);
      // stall when the instruction in E is a valid load whose rd this instruction reads
      hz = validD && m_e.valid && m_e.m2r && m_e.rd != 0 &&
           ((u1 && d.rs1 == m_e.rd) || (u2 && d.rs2 == m_e.rd));
      adv = !m_e.valid || readyE;
      rdy = flushD || (adv && !hz);
      n_checks++;
      if ({readyD, raddr1D, raddr2D} !== {rdy, ins[19:15], ins[24:20]})
        $display("FAIL rand_d c%0d: got %b %0d %0d want %b %0d %0d", c, readyD, raddr1D,
                 raddr2D, rdy, ins[19:15], ins[24:20]);
      else n_pass++;
      @(posedge clk);
      if (adv) begin
        if (flushD || hz || !validD) begin
          m_e.valid = 0; m_e.rw = 0; m_e.mw = 0; m_e.br = 0; m_e.fin = 0; m_e.m2r = 0;
        end else begin
          d.r1 = m_read(d.rs1); d.r2 = m_read(d.rs2); d.pc = pcD; d.valid = 1;
          m_e = d;
        end
        if (hz && !flushD) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_sat < 3) m_cnt_sat++;
        end
      end
      if (regWriteW && writeRegW != 0) m_regs[writeRegW] = resultW;
      #1;
      a = dut_e();
      n_checks++;
      if (m_e.valid) begin
        if (a !== m_e) $display("FAIL rand_e c%0d: got %h want %h", c, a, m_e);
        else n_pass++;
      end else begin
        if ({validE, regWriteE, memWriteE, branchE, finishE} !== 5'b0)
          $display("FAIL rand_bubble c%0d: got %b%b%b%b%b want 00000", c, validE, regWriteE,
                   memWriteE, branchE, finishE);
        else n_pass++;
      end
      n_checks++;
      if ({stallCount, s_stallCount} !== {16'(m_cnt), 2'(m_cnt_sat)})
        $display("FAIL rand_cnt c%0d: got %0d %0d want %0d %0d", c, stallCount, s_stallCount,
                 m_cnt, m_cnt_sat);
      else n_pass++;
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_x0();
    test_saturate_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
